prog_loader: RTL and testbench
==============================

Name: prog_loader

Overview:
- Boot-time program loader placed upstream of the pipelined RISC-V core's instruction memory.
- Receives a byte stream over a valid/ready handshake, packs it little-endian into 32-bit words, and writes the words sequentially into the program memory.
- Holds the core in reset until the image is fully written; on a framing error it keeps the core in reset.

Parameters:
- ADDR_WIDTH, 32, width of pm_addr (byte address).
- MAX_WORDS, 256, maximum accepted image length in words.
- BASE_ADDR, 0, byte address of the first written word; must be a multiple of 4.

Ports:
- systemClock  input  1  system clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-low reset.
- byte_data  input  8  incoming stream byte.
- byte_valid  input  1  byte_data is valid this cycle.
- byte_ready  output  1  loader can accept a byte this cycle.
- start  input  1  single-cycle pulse; restarts loading from DONE or ERR.
- pm_we  output  1  program-memory write enable, one-cycle pulse per word.
- pm_addr  output  ADDR_WIDTH  program-memory byte address.
- pm_wdata  output  32  program-memory write data.
- cpu_reset_n  output  1  active-low reset to the core; 1 only in DONE.
- done  output  1  image loaded successfully.
- error  output  1  load aborted.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=LEN_LO, byte counter=0, word index=0, shift register=0.
  - Outputs: pm_we=0, pm_addr=BASE_ADDR, pm_wdata=0, cpu_reset_n=0, done=0, error=0, byte_ready=1.
- Transfer rule: a byte transfers on a rising edge with byte_valid=1 and byte_ready=1. byte_ready is 1 only in LEN_LO, LEN_HI, DATA and CHK.
- All outputs are registered.
- States:
  - LEN_LO: on transfer, len[7:0]=byte; go to LEN_HI.
  - LEN_HI: on transfer, len[15:8]=byte, then:
    - len > MAX_WORDS -> ERR.
    - len == 0 -> CHK if the feature is enabled, else DONE.
    - otherwise -> DATA.
  - DATA: on each transfer, shift the byte into the word LSB first (first byte -> bits 7:0). On the 4th byte -> WRITE.
  - WRITE: exactly one cycle.
    - pm_we=1, pm_addr=BASE_ADDR+4*index, pm_wdata=assembled word.
    - Then index+1; if index+1 == len -> CHK (feature enabled) or DONE, else DATA.
    - byte_ready=0 in this cycle, so there is a 1-cycle bubble per word.
  - DONE: done=1, cpu_reset_n=1. start=1 -> LEN_LO; same edge sets cpu_reset_n=0, done=0, index=0, byte counter=0.
  - ERR: error=1, cpu_reset_n=0. start=1 -> LEN_LO; clears error, index, byte counter.
- start is ignored in LEN_LO, LEN_HI, DATA, WRITE and CHK.
- pm_addr keeps its last value outside WRITE. pm_we is 0 outside WRITE.
- Address arithmetic is modulo 2^ADDR_WIDTH. Index width is clog2(MAX_WORDS+1).
- Reset asserted mid-load: immediate return to the reset state. Partially written words are not rolled back.
- byte_valid may drop at any point; the loader waits indefinitely with no timeout.

Optional Feature:
- Macro PROG_LOADER_CHECKSUM_EN.
- Defined:
  - A running XOR of every transferred byte (length bytes included) is kept.
  - After the last word, state CHK accepts one more byte. If byte == running XOR -> DONE, else -> ERR.
  - The running XOR is cleared whenever state enters LEN_LO.
- Not defined: the CHK state and the XOR register are absent, and the stream ends with the last data byte.

Test Plan:
- Reset, then send 02 00 13 00 00 00 93 00 10 00 -> pm_we pulses twice: (addr 0x0, data 0x00000013) and (addr 0x4, data 0x00100093). Then done=1, cpu_reset_n=1. cpu_reset_n stays 0 throughout the load.
- Send 00 00 (checksum disabled) -> DONE within 1 cycle of the second byte, no pm_we pulse. Checksum enabled: 00 00 then 00 -> DONE; 00 00 then 01 -> error=1, cpu_reset_n=0.
- Length 01 01 (257 > MAX_WORDS) -> ERR, byte_ready=0, no writes. Pulse start -> state LEN_LO, error=0, byte_ready=1.
- Hold byte_valid=1 continuously for a 3-word image -> each word is accepted over 4 cycles plus 1 WRITE cycle, byte_ready=0 in WRITE. Toggle byte_valid randomly -> identical writes.
- Assert reset after the 6th data byte -> all outputs return to reset values immediately. A fresh image of 1 word, AABBCCDD bytes -> write at addr 0x0, data 0xDDCCBBAA.
- In DONE, pulse start and load a new image -> cpu_reset_n drops on the start edge and rises only after the new final WRITE; start pulses during DATA have no effect.

Source files
------------

// File: rtl/prog_loader.sv
// prog_loader: packs a byte stream little-endian into program-memory words and holds the core in reset until loaded; PROG_LOADER_CHECKSUM_EN adds a trailing XOR check byte
module prog_loader #(
  parameter int ADDR_WIDTH = 32,
  parameter int MAX_WORDS = 256,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0
) (
  input  logic                  systemClock,
  input  logic                  reset,
  input  logic [7:0]            byte_data,
  input  logic                  byte_valid,
  output logic                  byte_ready,
  input  logic                  start,
  output logic                  pm_we,
  output logic [ADDR_WIDTH-1:0] pm_addr,
  output logic [31:0]           pm_wdata,
  output logic                  cpu_reset_n,
  output logic                  done,
  output logic                  error
);
  localparam int IW = $clog2(MAX_WORDS + 1);
  typedef enum logic [2:0] {
    LEN_LO, LEN_HI, DATA, WRITE, DONE, ERR
`ifdef PROG_LOADER_CHECKSUM_EN
    , CHK
`endif
  } state_t;
`ifdef PROG_LOADER_CHECKSUM_EN
  localparam state_t LAST = CHK;
`else
  localparam state_t LAST = DONE;
`endif
  state_t state_q, state_d;
  logic [15:0] len_q, len_d;
  logic [1:0] cnt_q, cnt_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [31:0] shift_q, shift_d, pm_wdata_q, pm_wdata_d;
  logic [ADDR_WIDTH-1:0] pm_addr_q, pm_addr_d;
  logic byte_ready_q, pm_we_q, cpu_reset_n_q, done_q, error_q;
  logic ready_d, xfer;
`ifdef PROG_LOADER_CHECKSUM_EN
  logic [7:0] xor_q, xor_d;
`endif
  assign xfer = byte_valid && byte_ready_q;
  always_comb begin
    state_d = state_q;
    len_d = len_q;
    cnt_d = cnt_q;
    idx_d = idx_q;
    shift_d = shift_q;
    case (state_q)
      LEN_LO: if (xfer) begin
        len_d[7:0] = byte_data;
        state_d = LEN_HI;
      end
      LEN_HI: if (xfer) begin
        len_d[15:8] = byte_data;
        state_d = len_d > 16'(MAX_WORDS) ? ERR : len_d == 16'd0 ? LAST : DATA;
      end
      DATA: if (xfer) begin
        shift_d = {byte_data, shift_q[31:8]};
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == 2'd3) state_d = WRITE;
      end
      WRITE: begin
        idx_d = idx_q + IW'(1);
        state_d = 16'(idx_d) == len_q ? LAST : DATA;
      end
`ifdef PROG_LOADER_CHECKSUM_EN
      CHK: if (xfer) state_d = byte_data == xor_q ? DONE : ERR;
`endif
      DONE, ERR: if (start) begin
        state_d = LEN_LO;
        idx_d = '0;
        cnt_d = '0;
      end
      default: state_d = LEN_LO;
    endcase
    // Address and data are latched only on entry to WRITE so they hold afterwards
    pm_addr_d = state_d == WRITE ? BASE_ADDR + (ADDR_WIDTH'(idx_q) << 2) : pm_addr_q;
    pm_wdata_d = state_d == WRITE ? shift_d : pm_wdata_q;
    ready_d = state_d == LEN_LO || state_d == LEN_HI || state_d == DATA;
`ifdef PROG_LOADER_CHECKSUM_EN
    ready_d = ready_d || state_d == CHK;
    xor_d = state_d == LEN_LO ? 8'd0 : xfer ? xor_q ^ byte_data : xor_q;
`endif
  end
  always_ff @(posedge systemClock or negedge reset) begin
    if (!reset) begin
      state_q <= LEN_LO;
      len_q <= '0;
      cnt_q <= '0;
      idx_q <= '0;
      shift_q <= '0;
      pm_addr_q <= BASE_ADDR;
      pm_wdata_q <= '0;
      byte_ready_q <= 1'b1;
      pm_we_q <= 1'b0;
      cpu_reset_n_q <= 1'b0;
      done_q <= 1'b0;
      error_q <= 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
      xor_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      len_q <= len_d;
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      shift_q <= shift_d;
      pm_addr_q <= pm_addr_d;
      pm_wdata_q <= pm_wdata_d;
      byte_ready_q <= ready_d;
      pm_we_q <= state_d == WRITE;
      cpu_reset_n_q <= state_d == DONE;
      done_q <= state_d == DONE;
      error_q <= state_d == ERR;
`ifdef PROG_LOADER_CHECKSUM_EN
      xor_q <= xor_d;
`endif
    end
  end
  assign byte_ready = byte_ready_q;
  assign pm_we = pm_we_q;
  assign pm_addr = pm_addr_q;
  assign pm_wdata = pm_wdata_q;
  assign cpu_reset_n = cpu_reset_n_q;
  assign done = done_q;
  assign error = error_q;
endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: randomized image loads checked against a write-list model derived from the image bytes
module tb_prog_loader;
  localparam int AW = 32;
  localparam int MW = 256;
  localparam logic [31:0] BASE = 32'h0;
  typedef logic [7:0] bq_t[$];
  logic clk = 0, rst_n = 0, byte_valid = 0, start = 0;
  logic [7:0] byte_data = 0;
  logic byte_ready, pm_we, cpu_reset_n, done, error;
  logic [AW-1:0] pm_addr;
  logic [31:0] pm_wdata;
  int total = 0, bad = 0, stalls = 0, writes = 0;
  logic [31:0] exp_addr[$], exp_data[$];

  prog_loader #(.ADDR_WIDTH(AW), .MAX_WORDS(MW), .BASE_ADDR(BASE)) dut (
    .systemClock(clk), .reset(rst_n), .byte_data(byte_data), .byte_valid(byte_valid),
    .byte_ready(byte_ready), .start(start), .pm_we(pm_we), .pm_addr(pm_addr),
    .pm_wdata(pm_wdata), .cpu_reset_n(cpu_reset_n), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  always @(negedge clk) if (rst_n) begin
    check("cpu_rst_eq_done", 32'(cpu_reset_n), 32'(done));
    check("done_err_excl", 32'(done & error), 0);
    if (done) check("done_pending_writes", exp_addr.size(), 0);
    if (pm_we) begin
      writes++;
      check("ready_in_write", 32'(byte_ready), 0);
      if (exp_addr.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_write: addr %h data %h", pm_addr, pm_wdata);
      end else begin
        check("wr_addr", pm_addr, exp_addr.pop_front());
        check("wr_data", pm_wdata, exp_data.pop_front());
      end
    end
  end

  function automatic logic [31:0] exp_word(input bq_t img, input int i);
    return {img[5 + 4 * i], img[4 + 4 * i], img[3 + 4 * i], img[2 + 4 * i]};
  endfunction

  function automatic void push_image(input bq_t img);
    int len;
    len = int'(img[0]) + 256 * int'(img[1]);
    if (len <= MW)
      for (int i = 0; i < len; i++) begin
        exp_addr.push_back(BASE + 32'(4 * i));
        exp_data.push_back(exp_word(img, i));
      end
  endfunction

  function automatic bq_t make_image(input int n, input bq_t data);
    bq_t q;
    logic [7:0] x;
    q.push_back(n[7:0]);
    q.push_back(n[15:8]);
    foreach (data[i]) q.push_back(data[i]);
`ifdef PROG_LOADER_CHECKSUM_EN
    x = 0;
    foreach (q[i]) x ^= q[i];
    q.push_back(x);
`else
    x = 0;
`endif
    return q;
  endfunction

  function automatic bq_t rand_bytes(input int n);
    bq_t q;
    for (int i = 0; i < n; i++) q.push_back(8'($urandom));
    return q;
  endfunction

  task automatic send_byte(input logic [7:0] b, input bit gaps, input bit st);
    int n;
    if (gaps) begin
      byte_valid = 0;
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    byte_valid = 1;
    byte_data = b;
    start = st ? 1'($urandom_range(0, 1)) : 1'b0;
    n = 0;
    while (!byte_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    stalls += n;
    if (!byte_ready) begin
      total++;
      bad++;
      $display("FAIL send_timeout: byte %h never accepted", b);
    end else @(negedge clk);
  endtask

  task automatic send_image(input bq_t img, input bit gaps, input bit st);
    foreach (img[i]) send_byte(img[i], gaps, st && i < img.size() - 1);
    byte_valid = 0;
    start = 0;
  endtask

  task automatic wait_done(input string name, input int bound);
    int n = 0;
    while (!done && !error && n < bound) begin
      @(negedge clk);
      n++;
    end
    check(name, {30'd0, done, error}, 32'd2);
  endtask

  task automatic pulse_start();
    start = 1;
    @(negedge clk);
    start = 0;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_ready"}, 32'(byte_ready), 1);
    check({tag, "_we"}, 32'(pm_we), 0);
    check({tag, "_addr"}, pm_addr, BASE);
    check({tag, "_wdata"}, pm_wdata, 0);
    check({tag, "_cpu_rst"}, 32'(cpu_reset_n), 0);
    check({tag, "_done"}, 32'(done), 0);
    check({tag, "_err"}, 32'(error), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bq_t img, d;
    int n;
    repeat (2) @(negedge clk);
    check_idle("rst");
    rst_n = 1;
    @(negedge clk);
    check_idle("post_rst");
    img = make_image(2, '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00});
    check("model_w0", exp_word(img, 0), 32'h00000013);
    check("model_w1", exp_word(img, 1), 32'h00100093);
    push_image(img);
    send_image(img, 0, 0);
    wait_done("t1_done", 4);
    check("t1_cpu_rst", 32'(cpu_reset_n), 1);
    check("t1_writes", writes, 2);
    pulse_start();
    check("restart_cpu_rst", 32'(cpu_reset_n), 0);
    check("restart_done", 32'(done), 0);
    check("restart_ready", 32'(byte_ready), 1);
    img = make_image(0, d);
    n = writes;
    send_image(img, 0, 0);
    check("len0_done", 32'(done), 1);
    check("len0_no_write", writes, n);
`ifdef PROG_LOADER_CHECKSUM_EN
    pulse_start();
    send_image('{8'h00, 8'h00, 8'h01}, 0, 0);
    check("badchk_err", 32'(error), 1);
    check("badchk_cpu_rst", 32'(cpu_reset_n), 0);
    pulse_start();
`else
    pulse_start();
`endif
    send_image('{8'h01, 8'h01}, 0, 0);
    check("ovf_err", 32'(error), 1);
    check("ovf_ready", 32'(byte_ready), 0);
    check("ovf_no_write", writes, n);
    pulse_start();
    check("ovf_clr_err", 32'(error), 0);
    check("ovf_clr_ready", 32'(byte_ready), 1);
    img = make_image(3, rand_bytes(12));
    push_image(img);
    stalls = 0;
    send_image(img, 0, 0);
`ifdef PROG_LOADER_CHECKSUM_EN
    check("bubble_stalls", stalls, 3);
`else
    check("bubble_stalls", stalls, 2);
`endif
    wait_done("cont_done", 4);
    pulse_start();
    push_image(img);
    send_image(img, 1, 0);
    wait_done("gaps_done", 4);
    pulse_start();
    img = make_image(2, rand_bytes(8));
    push_image(img);
    for (int i = 0; i < 8; i++) send_byte(img[i], 1, 0);
    rst_n = 0;
    #1;
    check_idle("midrst");
    check("midrst_w0_written", exp_addr.size(), 1);
    exp_addr.delete();
    exp_data.delete();
    byte_valid = 0;
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    img = make_image(1, '{8'hAA, 8'hBB, 8'hCC, 8'hDD});
    check("model_aabbccdd", exp_word(img, 0), 32'hDDCCBBAA);
    push_image(img);
    send_image(img, 0, 0);
    wait_done("fresh_done", 4);
    pulse_start();
    check("reload_cpu_rst", 32'(cpu_reset_n), 0);
    img = make_image(2, rand_bytes(8));
    push_image(img);
    send_image(img, 1, 1);
    wait_done("reload_done", 4);
    for (int k = 0; k < 6; k++) begin
      pulse_start();
      n = $urandom_range(1, 6);
      img = make_image(n, rand_bytes(4 * n));
      push_image(img);
      send_image(img, 1, 1);
      wait_done("rand_done", 4);
    end
    check("final_queue_empty", exp_addr.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
